mul_err_sweeper: RTL and testbench

Hardware controller that sequences an 8x8 combinational multiplier through an exhaustive operand sweep and accumulates its error metrics on chip. It drives the multiplier operands, captures its product, compares it with the exact product and keeps the error sum, maximum error and correct/wrong counts. It sits beside any multiplier variant (accurate or compressor-based) in the evaluation top level. NED is then computed off-chip as sum_err / (N * max_err).

---
 rtl/mul_err_pkg.sv | 19 +
 rtl/mul_err_sweeper_if.sv | 11 +
 rtl/mul_err_sweeper_err_accum.sv | 75 +++++++
 rtl/mul_err_sweeper.sv | 129 ++++++++++++
 tb/tb_mul_err_sweeper.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_err_pkg.sv
// Shared types and constants for the multiplier error sweeper.
package mul_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam int unsigned DRAIN_CYC = 2;

  function automatic int unsigned n_pairs(input int unsigned w, input int unsigned lo);
    int unsigned span;
    span = (32'd1 << w) - lo;
    return span * span;
  endfunction

endpackage

// File: rtl/mul_err_sweeper_if.sv
// Operand/product bus between the sweeper and the multiplier under test.
interface mul_err_sweeper_if #(
  parameter int W = 8
);
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_s;

  modport master (output mul_a, output mul_b, input mul_s);
  modport slave  (input mul_a, input mul_b, output mul_s);
endinterface

// File: rtl/mul_err_sweeper_err_accum.sv
// Stage 2: absolute error of a captured product and the four result registers.
module err_accum #(
  parameter int W     = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [2*W-1:0]   mul_s_q,
  input  logic [2*W-1:0]   exact_q,
  input  logic             clr,
  output logic [ACC_W-1:0] sum_err,
  output logic [2*W-1:0]   max_err,
  output logic [2*W-1:0]   num_wrong,
  output logic [2*W-1:0]   num_correct
);

  logic [2*W:0]     dfull;
  logic [2*W:0]     dmag;
  logic [2*W-1:0]   diff;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [2*W-1:0]   max_q, max_d;
  logic [2*W-1:0]   wrong_q, wrong_d;
  logic [2*W-1:0]   correct_q, correct_d;

  // One extra bit keeps the sign of the difference; its magnitude always fits in 2W bits.
  always_comb begin
    dfull = {1'b0, mul_s_q} - {1'b0, exact_q};
    dmag  = dfull[2*W] ? (~dfull + 1'b1) : dfull;
    diff  = dmag[2*W-1:0];
  end

  always_comb begin
    sum_d     = sum_q;
    max_d     = max_q;
    wrong_d   = wrong_q;
    correct_d = correct_q;
    if (clr) begin
      sum_d     = '0;
      max_d     = '0;
      wrong_d   = '0;
      correct_d = '0;
    end else if (valid) begin
      sum_d = sum_q + ACC_W'(diff);
      if (diff > max_q) begin
        max_d = diff;
      end
      if (diff != '0) begin
        wrong_d = wrong_q + 1'b1;
      end else begin
        correct_d = correct_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      max_q     <= '0;
      wrong_q   <= '0;
      correct_q <= '0;
    end else begin
      sum_q     <= sum_d;
      max_q     <= max_d;
      wrong_q   <= wrong_d;
      correct_q <= correct_d;
    end
  end

  assign sum_err     = sum_q;
  assign max_err     = max_q;
  assign num_wrong   = wrong_q;
  assign num_correct = correct_q;

endmodule

// File: rtl/mul_err_sweeper.sv
// Sweeps all operand pairs LO..2^W-1 through an external multiplier and accumulates its error metrics.
module mul_err_sweeper
  import mul_err_pkg::*;
#(
  parameter int W     = 8,
  parameter int LO    = 1,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  mul_err_sweeper_if.master       mul,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_W-1:0]        sum_err,
  output logic [2*W-1:0]          max_err,
  output logic [2*W-1:0]          num_wrong,
  output logic [2*W-1:0]          num_correct
);

  localparam logic [W-1:0] OP_LO  = W'(LO);
  localparam logic [W-1:0] OP_MAX = '1;

  sweep_state_t   state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     drain_q, drain_d;
  logic           v1_q, v1_d;
  logic [2*W-1:0] s1_q, s1_d;
  logic [2*W-1:0] ex_q, ex_d;
  logic           clr;
  logic           acc_valid;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    drain_d = drain_q;
    v1_d    = 1'b0;
    s1_d    = s1_q;
    ex_d    = ex_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = OP_LO;
          b_d     = OP_LO;
          clr     = 1'b1;
        end
      end
      RUN: begin
        v1_d = 1'b1;
        s1_d = mul.mul_s;
        ex_d = (2*W)'(a_q) * (2*W)'(b_q);
        if (b_q == OP_MAX) begin
          b_d = OP_LO;
          if (a_q == OP_MAX) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            a_d = a_q + 1'b1;
          end
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'(DRAIN_CYC - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort overrides everything, including a start seen in the same cycle
    if (abort) begin
      state_d = IDLE;
      v1_d    = 1'b0;
      clr     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      drain_q <= '0;
      v1_q    <= 1'b0;
      s1_q    <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      drain_q <= drain_d;
      v1_q    <= v1_d;
      s1_q    <= s1_d;
      ex_q    <= ex_d;
    end
  end

  assign mul.mul_a = (state_q == RUN) ? a_q : '0;
  assign mul.mul_b = (state_q == RUN) ? b_q : '0;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign acc_valid = v1_q && !abort;

  err_accum #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (acc_valid),
    .mul_s_q     (s1_q),
    .exact_q     (ex_q),
    .clr         (clr),
    .sum_err     (sum_err),
    .max_err     (max_err),
    .num_wrong   (num_wrong),
    .num_correct (num_correct)
  );

endmodule

// File: tb/tb_mul_err_sweeper.sv
// Directed bench for mul_err_sweeper using a 4-bit operand instance (N = 15*15 = 225 pairs).
module tb_mul_err_sweeper;
  import mul_err_pkg::*;

  localparam int TW  = 4;
  localparam int TLO = 1;
  localparam int TN  = 225;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  logic [31:0]     sum_err;
  logic [2*TW-1:0] max_err, num_wrong, num_correct;
  int mode = 0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  mul_err_sweeper_if #(.W(TW)) bus ();

  mul_err_sweeper #(
    .W     (TW),
    .LO    (TLO),
    .ACC_W (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .mul         (bus),
    .busy        (busy),
    .done        (done),
    .sum_err     (sum_err),
    .max_err     (max_err),
    .num_wrong   (num_wrong),
    .num_correct (num_correct)
  );

  always #5 clk = ~clk;

  logic [2*TW-1:0] ex_p;
  always_comb begin
    ex_p = (2*TW)'(bus.mul_a) * (2*TW)'(bus.mul_b);
    case (mode)
      1:       bus.mul_s = '0;
      2:       bus.mul_s = ex_p + (2*TW)'(1);
      3:       bus.mul_s = ex_p & ~(2*TW)'(1);
      default: bus.mul_s = ex_p;
    endcase
  end

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    int          mode;
    logic [31:0] sum;
    logic [7:0]  mx;
    logic [7:0]  wrong;
    logic [7:0]  correct;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is at a negedge; start is sampled at the next posedge (E0).
  task automatic run_sweep(input int inj_start_at, output int lat);
    int k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    chk("op_a_k0", 64'(bus.mul_a), 64'(TLO));
    chk("op_b_k0", 64'(bus.mul_b), 64'(TLO));
    chk("busy_k0", 64'(busy), 64'd1);
    while (!done && k < TN + 50) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("op_a_k1", 64'(bus.mul_a), 64'(TLO));
        chk("op_b_k1", 64'(bus.mul_b), 64'(TLO + 1));
      end
      if (k == inj_start_at) start = 1'b1;
      if (k == inj_start_at + 1) start = 1'b0;
    end
    lat = k;
    chk("done_latency", 64'(lat), 64'(TN + 2));
    chk("busy_in_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic chk_results(input string tag, input vec_t v);
    chk({tag, "_sum"},     64'(sum_err),     64'(v.sum));
    chk({tag, "_max"},     64'(max_err),     64'(v.mx));
    chk({tag, "_wrong"},   64'(num_wrong),   64'(v.wrong));
    chk({tag, "_correct"}, 64'(num_correct), 64'(v.correct));
  endtask

  initial begin
    int lat;
    int d0;
    logic [7:0] cw, cc;

    // exact / all-zero / +1 / clear LSB (odd products: 8 odd a * 8 odd b = 64)
    vt[0] = '{mode: 0, sum: 32'd0,     mx: 8'd0,   wrong: 8'd0,   correct: 8'd225};
    vt[1] = '{mode: 1, sum: 32'd14400, mx: 8'd225, wrong: 8'd225, correct: 8'd0};
    vt[2] = '{mode: 2, sum: 32'd225,   mx: 8'd1,   wrong: 8'd225, correct: 8'd0};
    vt[3] = '{mode: 3, sum: 32'd64,    mx: 8'd1,   wrong: 8'd64,  correct: 8'd161};

    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum",  64'(sum_err), 64'd0);
    chk("rst_a",    64'(bus.mul_a), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mode = vt[i].mode;
      run_sweep(-1, lat);
      chk_results($sformatf("vec%0d", i), vt[i]);
      chk("idle_a_after", 64'(bus.mul_a), 64'd0);
      @(negedge clk);
    end

    // Abort while running, then restart on the cycle right after the abort edge.
    mode = 0;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_le99", 64'(32'(num_wrong) + 32'(num_correct) <= 99), 64'd1);
    cw = num_wrong;
    cc = num_correct;
    run_sweep(-1, lat);
    chk_results("restart", vt[0]);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd1);

    // Frozen partial results after abort (no restart).
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cc = num_correct;
    repeat (5) @(negedge clk);
    chk("abort_frozen", 64'(num_correct), 64'(cc));
    chk("abort_partial_nz", 64'(num_correct != 0), 64'd1);

    // start during RUN is ignored.
    @(negedge clk);
    mode = 2;
    run_sweep(50, lat);
    chk_results("midstart", vt[2]);

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd0);
    chk("start_abort_hold", 64'(sum_err), 64'd225);

    // Asynchronous reset mid-RUN.
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",    64'(busy), 64'd0);
    chk("arst_a",       64'(bus.mul_a), 64'd0);
    chk("arst_b",       64'(bus.mul_b), 64'd0);
    chk("arst_sum",     64'(sum_err), 64'd0);
    chk("arst_max",     64'(max_err), 64'd0);
    chk("arst_wrong",   64'(num_wrong), 64'd0);
    chk("arst_correct", 64'(num_correct), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
